// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 / stride-2 max-pooling stage.
// Takes a raster-order feature map as a valid-qualified beat stream and
// writes one pooled word per completed 2x2 window.
// Optional feature macro: MAXPOOL_RELU_EN clamps negative pooled results to 0.
//
// Stream semantics (input and output alike): there is no ready. A word
// transfers on every clock edge where its strobe is high, and the strobe
// never waits on the receiver. The input strobe i_mem_wr counts only while
// busy. The output strobe o_mem_wr is a one-cycle pulse per pooled word.
// o_mem_data and o_mem_addrs are valid during that pulse.
module maxpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 26,
  parameter int IMG_H      = 26,
  localparam int BUF_AW    = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1,
  localparam int OUT_AW    = ((IMG_W / 2) * (IMG_H / 2) > 1) ?
                             $clog2((IMG_W / 2) * (IMG_H / 2)) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  i_mem_wr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_mem_wr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [OUT_AW-1:0]     o_mem_addrs,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] din;
  logic signed [DATA_WIDTH-1:0] hmax;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic signed [DATA_WIDTH-1:0] pool_max;
  logic signed [DATA_WIDTH-1:0] pool_out;
  logic signed [DATA_WIDTH-1:0] linebuf [LB_DEPTH];
  logic [BUF_AW-1:0]            lb_addr;
  logic                         beat;
  logic                         clear;
  logic                         last_beat;

  // A beat that arrives together with start belongs to the aborted frame
  // and is dropped; the restart wins.
  assign beat      = (state == S_RUN) && i_mem_wr && !start;
  assign clear     = start && (state != S_FIN);
  assign last_beat = (row == ROW_LAST) && (col == COL_LAST);

  assign din      = i_mem_data;
  assign lb_addr  = BUF_AW'(col >> 1);
  assign lb_rd    = linebuf[lb_addr];
  assign hmax     = (hold > din) ? hold : din;
  assign pool_max = (hmax > lb_rd) ? hmax : lb_rd;

  assign busy      = (state == S_RUN);
  assign done      = (state == S_FIN);
  assign dbg_state = state;

  // Optional ReLU folded into the output register's input.
  always_comb begin
    pool_out = pool_max;
`ifdef MAXPOOL_RELU_EN
    if (pool_max < 0) pool_out = '0;
`else
    pool_out = pool_max;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: FIN lasts exactly one cycle and ignores start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (beat && last_beat) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Half-row buffer of horizontal maxima from the even row of each window pair.
  always_ff @(posedge clk) begin
    if (beat && col[0] && !row[0]) linebuf[lb_addr] <= hmax;
  end

  // Position counters, horizontal hold register and the registered output.
  // Odd col on an odd row always lies inside a full window, so trailing
  // odd-sized edges drop out without any extra test.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      hold        <= '0;
      o_mem_wr    <= 1'b0;
      o_mem_data  <= '0;
      o_mem_addrs <= '0;
    end else begin
      o_mem_wr <= 1'b0;
      if (o_mem_wr) o_mem_addrs <= o_mem_addrs + 1'b1;
      if (clear) begin
        col         <= '0;
        row         <= '0;
        o_mem_addrs <= '0;
      end else if (beat) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= last_beat ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          hold <= din;
        end else if (row[0]) begin
          o_mem_wr   <= 1'b1;
          o_mem_data <= pool_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: self-checking bench for maxpool_stream.
// Two instances share clock and reset: a 4x4 map and a 5x5 map.
// The reference computes each window maximum directly from the frame array.
module tb_maxpool_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;

  logic        start4 = 1'b0, wr4 = 1'b0;
  logic [15:0] d4 = '0;
  logic        o_wr4, busy4, done4;
  logic [15:0] o_d4;
  logic [1:0]  o_a4, dbg4;

  logic        start5 = 1'b0, wr5 = 1'b0;
  logic [15:0] d5 = '0;
  logic        o_wr5, busy5, done5;
  logic [15:0] o_d5;
  logic [1:0]  o_a5, dbg5;

  int tests_run = 0;
  int failed    = 0;

  logic signed [15:0] pix [0:35];
  int                 beat_cyc [0:35];

  logic [15:0] exp_q[$];
  int          exp_a[$];
  int          exp_c[$];
  logic [15:0] obs_d[$];
  int          obs_a[$];
  int          obs_c[$];
  int          done_c[$];

  maxpool_stream #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .i_mem_wr(wr4), .i_mem_data(d4),
    .o_mem_wr(o_wr4), .o_mem_data(o_d4), .o_mem_addrs(o_a4),
    .busy(busy4), .done(done4), .dbg_state(dbg4)
  );

  maxpool_stream #(.DATA_WIDTH(16), .IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .i_mem_wr(wr5), .i_mem_data(d5),
    .o_mem_wr(o_wr5), .o_mem_data(o_d5), .o_mem_addrs(o_a5),
    .busy(busy5), .done(done5), .dbg_state(dbg5)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: records every pulse and done away from the active edge
  always @(negedge clk) begin
    if (o_wr4) begin obs_d.push_back(o_d4); obs_a.push_back(int'(o_a4)); obs_c.push_back(cyc); end
    if (o_wr5) begin obs_d.push_back(o_d5); obs_a.push_back(int'(o_a5)); obs_c.push_back(cyc); end
    if (done4 || done5) done_c.push_back(cyc);
  end

  // Reference: every 2x2 window fully inside the map whose last beat
  // (bottom-right pixel) was among the first n beats yields one word.
  function automatic void build_exp(input int w, input int h, input int n);
    int a = 0;
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        int tl = (2 * r) * w + 2 * c;
        int bl = (2 * r + 1) * w + 2 * c;
        int m  = int'(pix[tl]);
        if (int'(pix[tl + 1]) > m) m = int'(pix[tl + 1]);
        if (int'(pix[bl])     > m) m = int'(pix[bl]);
        if (int'(pix[bl + 1]) > m) m = int'(pix[bl + 1]);
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        if (bl + 1 < n) begin
          exp_q.push_back(16'(m));
          exp_a.push_back(a);
          exp_c.push_back(beat_cyc[bl + 1] + 1);
          a++;
        end
      end
    end
  endfunction

  task automatic clear_obs();
    exp_q.delete(); exp_a.delete(); exp_c.delete();
    obs_d.delete(); obs_a.delete(); obs_c.delete(); done_c.delete();
  endtask

  task automatic pulse_start(input int sel);
    @(posedge clk); #1;
    if (sel == 0) start4 = 1'b1; else start5 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start5 = 1'b0;
  endtask

  // stall: 0 back-to-back, 1 idle cycle between beats, 2 random gaps
  task automatic drive(input int sel, input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      int gap = (stall == 1 && i > 0) ? 1 : (stall == 2 ? int'($urandom_range(0, 2)) : 0);
      repeat (gap) begin @(posedge clk); #1; wr4 = 1'b0; wr5 = 1'b0; end
      @(posedge clk); #1;
      if (sel == 0) begin wr4 = 1'b1; d4 = pix[i]; end
      else          begin wr5 = 1'b1; d5 = pix[i]; end
      beat_cyc[i] = cyc;
    end
    @(posedge clk); #1;
    wr4 = 1'b0; wr5 = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (o_wr4 !== 1'b0 || o_d4 !== 16'd0 || o_a4 !== 2'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || dbg4 !== 2'd0) begin
      failed++;
      $display("FAIL reset4: wr=%b data=%0h addr=%0d busy=%b done=%b st=%0d, required all zero",
               o_wr4, o_d4, o_a4, busy4, done4, dbg4);
    end
    tests_run++;
    if (o_wr5 !== 1'b0 || o_d5 !== 16'd0 || o_a5 !== 2'd0 || busy5 !== 1'b0 || done5 !== 1'b0 || dbg5 !== 2'd0) begin
      failed++;
      $display("FAIL reset5: wr=%b data=%0h addr=%0d busy=%b done=%b st=%0d, required all zero",
               o_wr5, o_d5, o_a5, busy5, done5, dbg5);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame4(input string name, input int kind, input int stall);
    clear_obs();
    for (int i = 0; i < 16; i++)
      pix[i] = (kind == 0) ? 16'(i) : (kind == 1) ? 16'(i - 16) : 16'($urandom);
    pulse_start(0);
    tests_run++;
    if (busy4 !== 1'b1 || dbg4 !== 2'd1) begin
      failed++;
      $display("FAIL %s busy: busy=%b st=%0d, required busy=1 st=1", name, busy4, dbg4);
    end
    drive(0, 16, stall);
    settle();
    build_exp(4, 4, 16);
    tests_run++;
    if (obs_d.size() != exp_q.size()) begin
      failed++;
      $display("FAIL %s count: got %0d words, required %0d", name, obs_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_q[i] || obs_a[i] != exp_a[i] || obs_c[i] != exp_c[i]) begin
        failed++;
        $display("FAIL %s word%0d: data=%0h addr=%0d cyc=%0d, required data=%0h addr=%0d cyc=%0d",
                 name, i, obs_d[i], obs_a[i], obs_c[i], exp_q[i], exp_a[i], exp_c[i]);
      end
    end
    tests_run++;
    if (done_c.size() != 1 || done_c[0] != beat_cyc[15] + 1) begin
      failed++;
      $display("FAIL %s done: %0d pulses first at cyc %0d, required 1 at cyc %0d",
               name, done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, beat_cyc[15] + 1);
    end
    tests_run++;
    if (busy4 !== 1'b0 || dbg4 !== 2'd0) begin
      failed++;
      $display("FAIL %s idle: busy=%b st=%0d, required busy=0 st=0", name, busy4, dbg4);
    end
  endtask

  task automatic test_odd_size(input string name, input bit rnd);
    clear_obs();
    for (int i = 0; i < 25; i++) pix[i] = rnd ? 16'($urandom) : 16'(i);
    pulse_start(1);
    drive(1, 25, rnd ? 2 : 0);
    settle();
    build_exp(5, 5, 25);
    tests_run++;
    if (obs_d.size() != 4) begin
      failed++;
      $display("FAIL %s count: got %0d words, required 4", name, obs_d.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_q[i] || obs_a[i] != exp_a[i] || obs_c[i] != exp_c[i]) begin
        failed++;
        $display("FAIL %s word%0d: data=%0h addr=%0d cyc=%0d, required data=%0h addr=%0d cyc=%0d",
                 name, i, obs_d[i], obs_a[i], obs_c[i], exp_q[i], exp_a[i], exp_c[i]);
      end
    end
    tests_run++;
    if (done_c.size() != 1 || done_c[0] != beat_cyc[24] + 1) begin
      failed++;
      $display("FAIL %s done: %0d pulses first at cyc %0d, required 1 at cyc %0d",
               name, done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, beat_cyc[24] + 1);
    end
  endtask

  task automatic test_restart();
    clear_obs();
    for (int i = 0; i < 6; i++) pix[i] = 16'($urandom);
    pulse_start(0);
    drive(0, 6, 0);
    build_exp(4, 4, 6);
    pulse_start(0);
    for (int i = 0; i < 16; i++) pix[i] = 16'(100 + i);
    drive(0, 16, 0);
    settle();
    build_exp(4, 4, 16);
    tests_run++;
    if (obs_d.size() != exp_q.size()) begin
      failed++;
      $display("FAIL restart count: got %0d words, required %0d", obs_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_q[i] || obs_a[i] != exp_a[i] || obs_c[i] != exp_c[i]) begin
        failed++;
        $display("FAIL restart word%0d: data=%0h addr=%0d cyc=%0d, required data=%0h addr=%0d cyc=%0d",
                 i, obs_d[i], obs_a[i], obs_c[i], exp_q[i], exp_a[i], exp_c[i]);
      end
    end
    tests_run++;
    if (done_c.size() != 1 || done_c[0] != beat_cyc[15] + 1) begin
      failed++;
      $display("FAIL restart done: %0d pulses first at cyc %0d, required 1 at cyc %0d",
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, beat_cyc[15] + 1);
    end
  endtask

  task automatic test_rst_mid();
    clear_obs();
    for (int i = 0; i < 16; i++) pix[i] = 16'($urandom);
    pulse_start(0);
    drive(0, 9, 0);
    build_exp(4, 4, 9);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (o_wr4 !== 1'b0 || o_d4 !== 16'd0 || o_a4 !== 2'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || dbg4 !== 2'd0) begin
      failed++;
      $display("FAIL rst_mid state: wr=%b data=%0h addr=%0d busy=%b done=%b st=%0d, required all zero",
               o_wr4, o_d4, o_a4, busy4, done4, dbg4);
    end
    rst = 1'b0;
    tests_run++;
    if (obs_d.size() != exp_q.size() || done_c.size() != 0) begin
      failed++;
      $display("FAIL rst_mid partial: got %0d words %0d done, required %0d words 0 done",
               obs_d.size(), done_c.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      tests_run++;
      if (obs_d[i] !== exp_q[i] || obs_a[i] != exp_a[i] || obs_c[i] != exp_c[i]) begin
        failed++;
        $display("FAIL rst_mid word%0d: data=%0h addr=%0d cyc=%0d, required data=%0h addr=%0d cyc=%0d",
                 i, obs_d[i], obs_a[i], obs_c[i], exp_q[i], exp_a[i], exp_c[i]);
      end
    end
    clear_obs();
    drive(0, 16, 0);
    settle();
    tests_run++;
    if (obs_d.size() != 0 || done_c.size() != 0 || busy4 !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid ignore: got %0d words %0d done busy=%b, required 0 words 0 done busy=0",
               obs_d.size(), done_c.size(), busy4);
    end
  endtask

  initial begin
    test_reset();
    test_frame4("basic", 0, 0);
    test_frame4("stall", 0, 1);
    test_frame4("negative", 1, 0);
    test_odd_size("odd5x5", 1'b0);
    test_restart();
    for (int k = 0; k < 4; k++) test_frame4("random4", 2, 2);
    for (int k = 0; k < 2; k++) test_odd_size("random5", 1'b1);
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
